// File: rtl/waveform_pkg.sv
// Shared encodings and constants for the waveform parameter controller.
// The ACCEL constants are only consumed when WAVEFSM_ACCEL_EN is defined.
package waveform_pkg;

   typedef enum logic [1:0] {
      MODE_FREQ  = 2'd0,
      MODE_AMP   = 2'd1,
      MODE_SHAPE = 2'd2,
      MODE_DUTY  = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      SHAPE_SINE     = 2'd0,
      SHAPE_SQUARE   = 2'd1,
      SHAPE_TRIANGLE = 2'd2,
      SHAPE_SAW      = 2'd3
   } shape_t;

   localparam int ACCEL_AFTER     = 8;
   localparam int FREQ_ACCEL_STEP = 10;
   localparam int AMP_ACCEL_STEP  = 8;
   localparam int REP_CNT_W       = 4;

   function automatic int clamp(input int value, input int lo, input int hi);
      if (value < lo) return lo;
      if (value > hi) return hi;
      return value;
   endfunction

endpackage

// File: rtl/waveform_param_fsm_if.sv
// Button levels in, generator settings out; master drives buttons, slave is the controller.
interface waveform_param_fsm_if #(
   parameter int FREQ_W = 23,
   parameter int AMP_W  = 8,
   parameter int DUTY_W = 7
);
   logic              increase;
   logic              decrease;
   logic              change_mode;
   logic [1:0]        mode;
   logic [FREQ_W-1:0] frequency;
   logic [AMP_W-1:0]  amplitude;
   logic [1:0]        shape;
   logic [DUTY_W-1:0] duty;

   modport master (
      output increase, decrease, change_mode,
      input  mode, frequency, amplitude, shape, duty
   );

   modport slave (
      input  increase, decrease, change_mode,
      output mode, frequency, amplitude, shape, duty
   );
endinterface

// File: rtl/button_repeat.sv
// Step pulse on press, then auto-repeat after REPEAT_DELAY and every REPEAT_RATE cycles while held.
// With WAVEFSM_ACCEL_EN the number of auto-repeats in the current hold is also reported.
module button_repeat
   import waveform_pkg::*;
#(
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 level,
`ifdef WAVEFSM_ACCEL_EN
   output logic [REP_CNT_W-1:0] repeat_count,
`endif
   output logic                 step
);
   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic             level_q;
   logic             armed;
   logic             repeating;
   logic [CNT_W-1:0] cnt;
   logic             last;

   assign last = repeating ? (cnt == CNT_W'(REPEAT_RATE - 1))
                           : (cnt == CNT_W'(REPEAT_DELAY - 1));

   // level_q resets high and armed low, so a hold spanning reset needs a fresh press
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_q   <= 1'b1;
         armed     <= 1'b0;
         repeating <= 1'b0;
         cnt       <= '0;
         step      <= 1'b0;
`ifdef WAVEFSM_ACCEL_EN
         repeat_count <= '0;
`endif
      end else begin
         level_q <= level;
         step    <= 1'b0;
         if (!level) begin
            armed     <= 1'b0;
            repeating <= 1'b0;
            cnt       <= '0;
`ifdef WAVEFSM_ACCEL_EN
            repeat_count <= '0;
`endif
         end else if (!level_q) begin
            armed     <= 1'b1;
            repeating <= 1'b0;
            cnt       <= '0;
            step      <= 1'b1;
`ifdef WAVEFSM_ACCEL_EN
            repeat_count <= '0;
`endif
         end else if (armed) begin
            if (last) begin
               step      <= 1'b1;
               cnt       <= '0;
               repeating <= 1'b1;
`ifdef WAVEFSM_ACCEL_EN
               if (repeat_count != '1) repeat_count <= repeat_count + 1'b1;
`endif
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/edgeDetector.sv
// Registered rising-edge pulse for a debounced level; a level held through reset is not an edge.
module edgeDetector (
   input  logic clk,
   input  logic reset_n,
   input  logic level,
   output logic pulse
);
   logic level_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_q <= 1'b1;
         pulse   <= 1'b0;
      end else begin
         level_q <= level;
         pulse   <= level & ~level_q;
      end
   end
endmodule

// File: rtl/waveform_param_fsm.sv
// Edit-mode controller for the waveform generator: FREQ/AMP/SHAPE/DUTY cycled by change_mode.
// Optional WAVEFSM_ACCEL_EN: coarser FREQ/AMP steps after ACCEL_AFTER auto-repeats in one hold.
module waveform_param_fsm
   import waveform_pkg::*;
#(
   parameter int FREQ_W       = 23,
   parameter int FREQ_CENTER  = 2147484,
   parameter int FREQ_STEP    = 4295,
   parameter int FREQ_IDX_MAX = 500,
   parameter int AMP_W        = 8,
   parameter int AMP_RESET    = 64,
   parameter int DUTY_W       = 7,
   parameter int DUTY_MIN     = 5,
   parameter int DUTY_MAX     = 95,
   parameter int DUTY_STEP    = 5,
   parameter int DUTY_RESET   = 50,
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
)(
   input  logic                clk,
   input  logic                reset_n,
   waveform_param_fsm_if.slave bus
);
   localparam int IDX_W   = $clog2(FREQ_IDX_MAX + 1) + 1;
   localparam int AMP_MAX = (1 << AMP_W) - 1;

   logic                    inc_step;
   logic                    dec_step;
   logic                    mode_step;
   mode_t                   mode_q, mode_d;
   logic signed [IDX_W-1:0] idx_q, idx_d;
   logic [AMP_W-1:0]        amp_q, amp_d;
   shape_t                  shape_q, shape_d;
   logic [DUTY_W-1:0]       duty_q, duty_d;
   logic [FREQ_W-1:0]       freq_q;
   int                      dir;
   int                      freq_mag;
   int                      amp_mag;

`ifdef WAVEFSM_ACCEL_EN
   logic [REP_CNT_W-1:0] inc_reps;
   logic [REP_CNT_W-1:0] dec_reps;
   logic                 accel;
`endif

   button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_inc (
      .clk          (clk),
      .reset_n      (reset_n),
      .level        (bus.increase),
`ifdef WAVEFSM_ACCEL_EN
      .repeat_count (inc_reps),
`endif
      .step         (inc_step)
   );

   button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_dec (
      .clk          (clk),
      .reset_n      (reset_n),
      .level        (bus.decrease),
`ifdef WAVEFSM_ACCEL_EN
      .repeat_count (dec_reps),
`endif
      .step         (dec_step)
   );

   edgeDetector u_mode (
      .clk     (clk),
      .reset_n (reset_n),
      .level   (bus.change_mode),
      .pulse   (mode_step)
   );

   // Simultaneous up and down pulses cancel out
   always_comb begin
      dir = 0;
      if (inc_step && !dec_step)      dir = 1;
      else if (dec_step && !inc_step) dir = -1;
   end

`ifdef WAVEFSM_ACCEL_EN
   // repeat_count already includes the pulse being applied, so the (ACCEL_AFTER+1)th repeat is coarse
   always_comb begin
      accel = 1'b0;
      if (inc_step && !dec_step)      accel = int'(inc_reps) > ACCEL_AFTER;
      else if (dec_step && !inc_step) accel = int'(dec_reps) > ACCEL_AFTER;
   end
   assign freq_mag = accel ? FREQ_ACCEL_STEP : 1;
   assign amp_mag  = accel ? AMP_ACCEL_STEP : 1;
`else
   assign freq_mag = 1;
   assign amp_mag  = 1;
`endif

   // Steps use the current mode; a mode advance in the same cycle only lands afterwards
   always_comb begin
      mode_d  = mode_q;
      idx_d   = idx_q;
      amp_d   = amp_q;
      shape_d = shape_q;
      duty_d  = duty_q;
      case (mode_q)
         MODE_FREQ: begin
            if (dir != 0)
               idx_d = IDX_W'(clamp(int'(idx_q) + dir * freq_mag, -FREQ_IDX_MAX, FREQ_IDX_MAX));
            if (mode_step) mode_d = MODE_AMP;
         end
         MODE_AMP: begin
            if (dir != 0)
               amp_d = AMP_W'(clamp(int'(amp_q) + dir * amp_mag, 0, AMP_MAX));
            if (mode_step) mode_d = MODE_SHAPE;
         end
         MODE_SHAPE: begin
            if (dir > 0)      shape_d = shape_t'(shape_q + 2'd1);
            else if (dir < 0) shape_d = shape_t'(shape_q - 2'd1);
            if (mode_step) mode_d = MODE_DUTY;
         end
         MODE_DUTY: begin
            if (dir != 0)
               duty_d = DUTY_W'(clamp(int'(duty_q) + dir * DUTY_STEP, DUTY_MIN, DUTY_MAX));
            if (mode_step) mode_d = MODE_FREQ;
         end
         default: mode_d = MODE_FREQ;
      endcase
   end

   // Tuning word trails the index by one cycle, computed with a signed index
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q  <= MODE_FREQ;
         idx_q   <= '0;
         amp_q   <= AMP_W'(AMP_RESET);
         shape_q <= SHAPE_SINE;
         duty_q  <= DUTY_W'(DUTY_RESET);
         freq_q  <= FREQ_W'(FREQ_CENTER);
      end else begin
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         amp_q   <= amp_d;
         shape_q <= shape_d;
         duty_q  <= duty_d;
         freq_q  <= FREQ_W'(FREQ_CENTER + FREQ_STEP * int'(idx_q));
      end
   end

   assign bus.mode      = mode_q;
   assign bus.frequency = freq_q;
   assign bus.amplitude = amp_q;
   assign bus.shape     = shape_q;
   assign bus.duty      = duty_q;
endmodule
